seq_core: RTL and testbench
===========================

# seq_core

Parametrised multicycle processor core: the successor to the single-cycle 9-bit top level. It has configurable data width, register count and PC width, an internal carry flag and an FSM sequencer. Instruction and data memories are external and reached through req/ack handshakes, so wait-stated memories are tolerated. It sits directly under the test harness and exposes start/halt plus cycle and retired-instruction counters.

## Interface
- DW, 8: data/register width (>=4)
- NREG, 8: register count, power of two; RA_W = $clog2(NREG); IW = 3 + 2*RA_W (9 at defaults)
- PCW, 10: PC width
- CTW, 16: counter width
- CLK  in  1  clock, posedge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  run request; sampled only in IDLE/HALTED
- halt  out  1  high in HALTED
- imem_req  out  1  instruction fetch request
- imem_addr  out  PCW  fetch address (= PC)
- imem_ack  in  1  fetch complete; imem_data valid this cycle
- imem_data  in  IW  instruction word
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store
- dmem_addr  out  DW  data address
- dmem_wdata  out  DW  store data
- dmem_ack  in  1  access complete; dmem_rdata valid on load
- dmem_rdata  in  DW  load data
- cycle_ct  out  CTW  cycles spent in FETCH/EXEC/MEM
- instr_ct  out  CTW  retired instructions

## Operation
- Instruction fields: op = [IW-1:IW-3], a = next RA_W bits, b = low RA_W bits.
- ADD 000: r[a] <= r[a]+r[b]; C <= carry-out.
- ADC 001: r[a] <= r[a]+r[b]+C; C <= carry-out.
- SUB 010: r[a] <= r[a]-r[b]; C <= 1 on borrow.
- AND 011: r[a] <= r[a]&r[b]; C unchanged.
- SHL 100: r[a] <= {r[a][DW-2:0],C}; C <= old r[a][DW-1]; b ignored.
- LD 101: r[a] <= mem[r[b]].
- ST 110: mem[r[b]] <= r[a].
- BRZ 111: b==0 means HALT. Otherwise, if r[a]==0, PC <= PC + sext(b), else PC <= PC+1.
- Non-branch instructions: PC <= PC+1. PC wraps modulo 2^PCW.
- FSM states: IDLE, FETCH, EXEC, MEM, HALTED.
  - IDLE: start -> FETCH.
  - FETCH: imem_req=1; on imem_ack latch IR, -> EXEC.
  - EXEC: ALU/branch ops update state, retire, -> FETCH. LD/ST -> MEM. HALT retires, -> HALTED.
  - MEM: dmem_req=1; on dmem_ack, LD writes r[a], retire, -> FETCH.
  - HALTED: start -> FETCH.
- Start handling:
  - A start accepted from IDLE or HALTED sets PC <= 0, C <= 0 and clears both counters.
  - Registers are retained across starts.
  - start in FETCH/EXEC/MEM is ignored.
- Counters saturate at all-ones.
- Reset values: state IDLE, PC 0, C 0, all registers 0, counters 0. All outputs are 0, including halt (halt is 0 in IDLE).

## Timing
- Handshakes:
  - A req stays high, with addr/we/wdata stable, until the ack edge.
  - req drops in the cycle after ack.
  - ack may arrive in the first req cycle.
  - ack while req is low is ignored.
- Minimum latency: ALU/branch/HALT 2 cycles (FETCH+EXEC); LD/ST 3 cycles. Each ack wait cycle adds one.
- cycle_ct increments on every edge where state is FETCH, EXEC or MEM.
- instr_ct increments on the retire edge.
- Register, C and PC updates take effect at the retire edge; the next FETCH uses the updated PC.
- A reset_n assertion mid-handshake drops req asynchronously. The late ack is ignored.
- halt rises on the edge after HALT's EXEC cycle.

## Structure
- Package seq_core_pkg: opcode enum op_e, state enum state_e, localparams for field offsets.
- Sub-module seq_core_alu (combinational): inputs a, b, cin, op; outputs y, cout, zero.
- Register file, PC, IR, C and counters live in seq_core.

## Test plan
- Zero-wait memory. Program ADD r1=3+4; HALT -> r1=7, instr_ct=2, cycle_ct=4, halt=1.
- imem_ack delayed 3 cycles per fetch -> imem_addr and imem_req held stable throughout; cycle_ct grows by 3 per instruction.
- Carry chain: r0=0xFF, r1=0x01, ADD r0,r1 then ADC r2,r3 (r2=r3=0) -> r0=0x00, C=1 after ADD, r2=0x01.
- LD/ST, 2-cycle dmem wait: ST r4=0x5A to [0x10], LD r5 from [0x10] -> dmem_wdata=0x5A, r5=0x5A, MEM state lasts 2 cycles each.
- BRZ with b=-1 while r[a] != 0 -> falls through. With r[a]==0 -> branches back. PC wrap from 0x3FF to 0x000 verified.
- reset_n asserted during MEM -> dmem_req=0 immediately, outputs reset, halt=0. A subsequent start restarts at PC 0.

Source files
------------

// File: rtl/seq_core_pkg.sv
// Shared types and instruction-field helpers for the seq_core multicycle processor.
// Exports: op_e (opcodes), state_e (sequencer states), field width/offset helpers.
package seq_core_pkg;

   localparam int unsigned OP_W  = 3;
   localparam int unsigned B_LSB = 0;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_ADC = 3'b001,
      OP_SUB = 3'b010,
      OP_AND = 3'b011,
      OP_SHL = 3'b100,
      OP_LD  = 3'b101,
      OP_ST  = 3'b110,
      OP_BRZ = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_HALTED = 3'd4
   } state_e;

   // Instruction word is {op, a, b}; the register-address width sets the layout.
   function automatic int unsigned instr_width(input int unsigned ra_w);
      return OP_W + 2 * ra_w;
   endfunction

   function automatic int unsigned op_lsb(input int unsigned ra_w);
      return 2 * ra_w;
   endfunction

   function automatic int unsigned a_lsb(input int unsigned ra_w);
      return ra_w;
   endfunction

endpackage

// File: rtl/seq_core_if.sv
// Instruction and data memory req/ack handshake bundle for seq_core.
// master: the core (drives req/addr/we/wdata); slave: the memories (drive ack/data).
interface seq_core_if #(
   parameter int unsigned PCW = 10,
   parameter int unsigned IW  = 9,
   parameter int unsigned DW  = 8
) ();

   logic           imem_req;
   logic [PCW-1:0] imem_addr;
   logic           imem_ack;
   logic [IW-1:0]  imem_data;

   logic           dmem_req;
   logic           dmem_we;
   logic [DW-1:0]  dmem_addr;
   logic [DW-1:0]  dmem_wdata;
   logic           dmem_ack;
   logic [DW-1:0]  dmem_rdata;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_data,
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_data,
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ack, dmem_rdata
   );

endinterface

// File: rtl/seq_core_alu.sv
// Combinational ALU for seq_core.
// Ports: a/b operands, cin carry in, op opcode -> y result, cout carry out, zero (y == 0).
// Opcodes without an ALU function pass a through, so zero doubles as the BRZ test on r[a].
module seq_core_alu
   import seq_core_pkg::*;
#(
   parameter int unsigned DW = 8
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic          cin,
   input  op_e           op,
   output logic [DW-1:0] y,
   output logic          cout,
   output logic          zero
);

   logic [DW:0] ext;

   // Result and carry select; carry holds unless the opcode defines it.
   always_comb begin
      ext  = {1'b0, a};
      y    = a;
      cout = cin;
      case (op)
         OP_ADD: begin
            ext  = {1'b0, a} + {1'b0, b};
            y    = ext[DW-1:0];
            cout = ext[DW];
         end
         OP_ADC: begin
            ext  = {1'b0, a} + {1'b0, b} + (DW+1)'(cin);
            y    = ext[DW-1:0];
            cout = ext[DW];
         end
         OP_SUB: begin
            // Top bit of the widened difference is the borrow.
            ext  = {1'b0, a} - {1'b0, b};
            y    = ext[DW-1:0];
            cout = ext[DW];
         end
         OP_AND: y = a & b;
         OP_SHL: begin
            y    = {a[DW-2:0], cin};
            cout = a[DW-1];
         end
         default: ;
      endcase
   end

   assign zero = (y == '0);

endmodule

// File: rtl/seq_core.sv
// seq_core: parametrised multicycle processor with FSM sequencer.
// Ports: CLK, reset_n (async active-low), start (run request in IDLE/HALTED),
//        halt (high in HALTED), cycle_ct / instr_ct (saturating counters),
//        mem (seq_core_if master: instruction and data memory handshakes).
module seq_core
   import seq_core_pkg::*;
#(
   parameter int unsigned DW   = 8,
   parameter int unsigned NREG = 8,
   parameter int unsigned PCW  = 10,
   parameter int unsigned CTW  = 16
) (
   input  logic           CLK,
   input  logic           reset_n,
   input  logic           start,
   output logic           halt,
   output logic [CTW-1:0] cycle_ct,
   output logic [CTW-1:0] instr_ct,
   seq_core_if.master     mem
);

   localparam int unsigned RA_W   = $clog2(NREG);
   localparam int unsigned IW     = instr_width(RA_W);
   localparam int unsigned OP_LSB = op_lsb(RA_W);
   localparam int unsigned A_LSB  = a_lsb(RA_W);

   state_e          state_q, state_d;
   logic [PCW-1:0]  pc_q, pc_d;
   logic [IW-1:0]   ir_q;
   logic            c_q, c_d;
   logic [DW-1:0]   rf_q [NREG];

   logic            imem_req_q;
   logic            dmem_req_q;
   logic            dmem_we_q;
   logic [DW-1:0]   dmem_addr_q;
   logic [DW-1:0]   dmem_wdata_q;

   logic            start_go, retire, ir_ld, mem_go, wr_en;
   logic [DW-1:0]   wr_data;

   op_e             op;
   logic [RA_W-1:0] fa, fb;
   logic [DW-1:0]   ra_val, rb_val;
   logic [DW-1:0]   alu_y;
   logic            alu_cout, alu_zero;
   logic [PCW-1:0]  pc_inc, br_target;
   logic            running;

   // Instruction field decode from the latched IR.
   assign op        = op_e'(ir_q[OP_LSB +: OP_W]);
   assign fa        = ir_q[A_LSB +: RA_W];
   assign fb        = ir_q[B_LSB +: RA_W];
   assign ra_val    = rf_q[fa];
   assign rb_val    = rf_q[fb];
   assign pc_inc    = pc_q + PCW'(1);
   assign br_target = pc_q + {{(PCW-RA_W){fb[RA_W-1]}}, fb};
   assign running   = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_MEM);

   seq_core_alu #(.DW(DW)) u_alu (
      .a    (ra_val),
      .b    (rb_val),
      .cin  (c_q),
      .op   (op),
      .y    (alu_y),
      .cout (alu_cout),
      .zero (alu_zero)
   );

   // Sequencer state register.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next state plus architectural update strobes.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      c_d      = c_q;
      start_go = 1'b0;
      retire   = 1'b0;
      ir_ld    = 1'b0;
      mem_go   = 1'b0;
      wr_en    = 1'b0;
      wr_data  = alu_y;
      case (state_q)
         S_IDLE, S_HALTED: begin
            if (start) begin
               state_d  = S_FETCH;
               start_go = 1'b1;
               pc_d     = '0;
               c_d      = 1'b0;
            end
         end
         S_FETCH: begin
            if (mem.imem_ack) begin
               ir_ld   = 1'b1;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (op == OP_LD || op == OP_ST) begin
               mem_go  = 1'b1;
               state_d = S_MEM;
            end else if (op == OP_BRZ) begin
               retire = 1'b1;
               if (fb == '0) begin
                  state_d = S_HALTED;
               end else begin
                  state_d = S_FETCH;
                  pc_d    = alu_zero ? br_target : pc_inc;
               end
            end else begin
               retire  = 1'b1;
               wr_en   = 1'b1;
               c_d     = alu_cout;
               pc_d    = pc_inc;
               state_d = S_FETCH;
            end
         end
         S_MEM: begin
            if (mem.dmem_ack) begin
               retire  = 1'b1;
               pc_d    = pc_inc;
               state_d = S_FETCH;
               if (op == OP_LD) begin
                  wr_en   = 1'b1;
                  wr_data = mem.dmem_rdata;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // PC, carry, IR and register file.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         pc_q <= '0;
         c_q  <= 1'b0;
         ir_q <= '0;
         for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
      end else begin
         pc_q <= pc_d;
         c_q  <= c_d;
         if (ir_ld) ir_q <= mem.imem_data;
         if (wr_en) rf_q[fa] <= wr_data;
      end
   end

   // Registered handshake outputs; request levels track the state being entered.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         imem_req_q   <= 1'b0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
         halt         <= 1'b0;
      end else begin
         imem_req_q <= (state_d == S_FETCH);
         dmem_req_q <= (state_d == S_MEM);
         halt       <= (state_d == S_HALTED);
         if (mem_go) begin
            dmem_we_q    <= (op == OP_ST);
            dmem_addr_q  <= rb_val;
            dmem_wdata_q <= ra_val;
         end
      end
   end

   // Saturating cycle and retired-instruction counters, cleared by an accepted start.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         cycle_ct <= '0;
         instr_ct <= '0;
      end else if (start_go) begin
         cycle_ct <= '0;
         instr_ct <= '0;
      end else begin
         if (running && cycle_ct != '1) cycle_ct <= cycle_ct + CTW'(1);
         if (retire && instr_ct != '1)  instr_ct <= instr_ct + CTW'(1);
      end
   end

   assign mem.imem_req   = imem_req_q;
   assign mem.imem_addr  = pc_q;
   assign mem.dmem_req   = dmem_req_q;
   assign mem.dmem_we    = dmem_we_q;
   assign mem.dmem_addr  = dmem_addr_q;
   assign mem.dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_seq_core.sv
// Self-checking bench for seq_core: wait-stated memory responders, store and
// fetch-address scoreboards, directed programs run one after another.
module tb_seq_core;
   import seq_core_pkg::*;

   localparam int unsigned DW   = 8;
   localparam int unsigned NREG = 8;
   localparam int unsigned PCW  = 10;
   localparam int unsigned CTW  = 8;
   localparam int unsigned IW   = 9;

   typedef struct packed {
      logic [DW-1:0] addr;
      logic [DW-1:0] data;
   } st_t;

   logic           CLK = 1'b0;
   logic           reset_n = 1'b1;
   logic           start = 1'b0;
   logic           halt;
   logic [CTW-1:0] cycle_ct, instr_ct;

   logic [IW-1:0]  imem [1024];
   logic [DW-1:0]  dmem [256];
   int             imem_wait = 0;
   int             dmem_wait = 0;
   int             dreq_cycles = 0;
   int             n_tests = 0;
   int             n_fail = 0;
   st_t            st_q[$];
   logic [PCW-1:0] fa_q[$];

   seq_core_if #(.PCW(PCW), .IW(IW), .DW(DW)) bus ();

   seq_core #(.DW(DW), .NREG(NREG), .PCW(PCW), .CTW(CTW)) dut (
      .CLK      (CLK),
      .reset_n  (reset_n),
      .start    (start),
      .halt     (halt),
      .cycle_ct (cycle_ct),
      .instr_ct (instr_ct),
      .mem      (bus)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [IW-1:0] ins(input logic [2:0] op, input int a, input int b);
      return {op, 3'(a), 3'(b)};
   endfunction

   // Instruction memory responder: ack after imem_wait extra request cycles.
   initial begin : imem_resp
      int cnt;
      logic acked;
      logic [PCW-1:0] a0;
      cnt = 0;
      acked = 1'b0;
      a0 = '0;
      bus.imem_ack  = 1'b0;
      bus.imem_data = '0;
      forever begin
         @(negedge CLK);
         if (acked) chk("imem_req_drop", 32'(bus.imem_req), 32'(0));
         acked = 1'b0;
         if (bus.imem_req === 1'b1) begin
            if (cnt == 0) a0 = bus.imem_addr;
            else chk("imem_addr_hold", 32'(bus.imem_addr), 32'(a0));
            if (cnt == imem_wait) begin
               bus.imem_ack  = 1'b1;
               bus.imem_data = imem[bus.imem_addr];
               acked = 1'b1;
               cnt = 0;
               if (fa_q.size() > 0) chk("fetch_addr", 32'(bus.imem_addr), 32'(fa_q.pop_front()));
            end else begin
               bus.imem_ack = 1'b0;
               cnt++;
            end
         end else begin
            bus.imem_ack = 1'b0;
            cnt = 0;
         end
      end
   end

   // Data memory responder: stores are checked against the expected-store queue.
   initial begin : dmem_resp
      int cnt;
      logic acked;
      st_t exp_st;
      logic [DW-1:0] a0, d0;
      logic w0;
      cnt = 0;
      acked = 1'b0;
      a0 = '0;
      d0 = '0;
      w0 = 1'b0;
      bus.dmem_ack   = 1'b0;
      bus.dmem_rdata = '0;
      forever begin
         @(negedge CLK);
         if (acked) chk("dmem_req_drop", 32'(bus.dmem_req), 32'(0));
         acked = 1'b0;
         if (bus.dmem_req === 1'b1) begin
            dreq_cycles++;
            if (cnt == 0) begin
               a0 = bus.dmem_addr;
               d0 = bus.dmem_wdata;
               w0 = bus.dmem_we;
            end else begin
               chk("dmem_addr_hold", 32'(bus.dmem_addr), 32'(a0));
               chk("dmem_wdata_hold", 32'(bus.dmem_wdata), 32'(d0));
               chk("dmem_we_hold", 32'(bus.dmem_we), 32'(w0));
            end
            if (cnt == dmem_wait) begin
               bus.dmem_ack = 1'b1;
               acked = 1'b1;
               cnt = 0;
               if (bus.dmem_we === 1'b1) begin
                  dmem[bus.dmem_addr] = bus.dmem_wdata;
                  if (st_q.size() == 0) begin
                     chk("store_unexpected", 32'(bus.dmem_addr), 32'hFFFF_FFFF);
                  end else begin
                     exp_st = st_q.pop_front();
                     chk("store_addr", 32'(bus.dmem_addr), 32'(exp_st.addr));
                     chk("store_data", 32'(bus.dmem_wdata), 32'(exp_st.data));
                  end
               end else begin
                  bus.dmem_rdata = dmem[bus.dmem_addr];
               end
            end else begin
               bus.dmem_ack = 1'b0;
               cnt++;
            end
         end else begin
            bus.dmem_ack = 1'b0;
            cnt = 0;
         end
      end
   end

   task automatic clear_imem();
      for (int i = 0; i < 1024; i++) imem[i] = ins(OP_BRZ, 0, 0);
   endtask

   task automatic push_st(input logic [DW-1:0] a, input logic [DW-1:0] d);
      st_q.push_back({a, d});
   endtask

   // Assert reset between edges, check outputs clear immediately, release later.
   task automatic do_reset(input string tag);
      @(negedge CLK);
      #2 reset_n = 1'b0;
      #1;
      chk({tag, "_rst_halt"}, 32'(halt), 32'(0));
      chk({tag, "_rst_cyc"}, 32'(cycle_ct), 32'(0));
      chk({tag, "_rst_ins"}, 32'(instr_ct), 32'(0));
      chk({tag, "_rst_ireq"}, 32'(bus.imem_req), 32'(0));
      chk({tag, "_rst_dreq"}, 32'(bus.dmem_req), 32'(0));
      chk({tag, "_rst_iaddr"}, 32'(bus.imem_addr), 32'(0));
      repeat (2) @(negedge CLK);
      reset_n = 1'b1;
   endtask

   // Pulse start, wait (bounded) for halt; poke re-asserts start mid-run.
   task automatic run(input string tag, input int budget, input int poke);
      int n;
      n = 0;
      @(negedge CLK) start = 1'b1;
      @(negedge CLK) start = 1'b0;
      while (halt !== 1'b1 && n < budget) begin
         @(negedge CLK);
         n++;
         start = (n == poke);
      end
      start = 1'b0;
      chk({tag, "_halt"}, 32'(halt), 32'(1));
      chk({tag, "_stq_empty"}, 32'(st_q.size()), 32'(0));
      chk({tag, "_faq_empty"}, 32'(fa_q.size()), 32'(0));
   endtask

   task automatic chk_ct(input string tag, input int cyc, input int icnt);
      chk({tag, "_cycle_ct"}, 32'(cycle_ct), 32'(cyc));
      chk({tag, "_instr_ct"}, 32'(instr_ct), 32'(icnt));
   endtask

   initial begin : main
      int n;
      for (int i = 0; i < 256; i++) dmem[i] = '0;
      clear_imem();
      do_reset("init");

      // Basic ADD: load 3 and 4, add, then store the sum.
      dmem[0] = 8'h03;
      dmem[3] = 8'h04;
      imem[0] = ins(OP_LD, 1, 0);
      imem[1] = ins(OP_LD, 2, 1);
      imem[2] = ins(OP_BRZ, 0, 0);
      run("setup_add", 40, 0);
      clear_imem();
      imem[0] = ins(OP_ADD, 1, 2);
      imem[1] = ins(OP_BRZ, 0, 0);
      run("add", 40, 0);
      chk_ct("add", 4, 2);
      clear_imem();
      imem[0] = ins(OP_ST, 1, 0);
      push_st(8'h00, 8'h07);
      run("add_obs", 40, 0);
      chk_ct("add_obs", 5, 2);

      // Fetch wait states; a start pulse mid-run must be ignored.
      imem_wait = 3;
      clear_imem();
      imem[0] = ins(OP_ADD, 3, 3);
      imem[1] = ins(OP_ADD, 3, 3);
      run("iwait", 80, 4);
      chk_ct("iwait", 15, 3);
      imem_wait = 0;

      // Carry chain, SUB borrow, SHL through carry, AND.
      do_reset("carry");
      dmem[0]    = 8'hFF;
      dmem[8'hFF] = 8'h01;
      clear_imem();
      imem[0] = ins(OP_LD, 0, 0);
      imem[1] = ins(OP_LD, 1, 0);
      run("setup_carry", 40, 0);
      clear_imem();
      imem[0]  = ins(OP_ADD, 0, 1);
      imem[1]  = ins(OP_ADC, 2, 3);
      imem[2]  = ins(OP_ST, 0, 5);
      imem[3]  = ins(OP_ST, 2, 5);
      imem[4]  = ins(OP_SUB, 0, 1);
      imem[5]  = ins(OP_SHL, 3, 0);
      imem[6]  = ins(OP_ST, 0, 5);
      imem[7]  = ins(OP_ST, 3, 5);
      imem[8]  = ins(OP_AND, 0, 2);
      imem[9]  = ins(OP_SHL, 0, 0);
      imem[10] = ins(OP_ST, 0, 5);
      push_st(8'h00, 8'h00);
      push_st(8'h00, 8'h01);
      push_st(8'h00, 8'hFF);
      push_st(8'h00, 8'h01);
      push_st(8'h00, 8'h02);
      run("carry", 100, 0);
      chk_ct("carry", 29, 12);

      // Store then load through a 2-cycle MEM phase.
      do_reset("ldst");
      dmem[0]     = 8'h10;
      dmem[8'h10] = 8'h5A;
      clear_imem();
      imem[0] = ins(OP_LD, 1, 0);
      imem[1] = ins(OP_LD, 4, 1);
      run("setup_ldst", 40, 0);
      dmem[8'h10] = 8'h00;
      dmem_wait = 1;
      dreq_cycles = 0;
      clear_imem();
      imem[0] = ins(OP_ST, 4, 1);
      imem[1] = ins(OP_LD, 5, 1);
      imem[2] = ins(OP_ST, 5, 0);
      push_st(8'h10, 8'h5A);
      push_st(8'h00, 8'h5A);
      run("ldst", 60, 0);
      chk_ct("ldst", 14, 4);
      chk("ldst_mem_cycles", 32'(dreq_cycles), 32'(6));
      dmem_wait = 0;

      // BRZ with offset -1: fall through when nonzero, branch back when zero.
      dmem[8'h5A] = 8'h01;
      clear_imem();
      imem[0] = ins(OP_LD, 6, 4);
      imem[1] = ins(OP_LD, 7, 4);
      run("setup_brz", 40, 0);
      clear_imem();
      imem[0] = ins(OP_BRZ, 1, -1);
      imem[1] = ins(OP_SUB, 6, 7);
      imem[2] = ins(OP_BRZ, 6, -1);
      imem[3] = ins(OP_ST, 6, 0);
      fa_q = '{10'h000, 10'h001, 10'h002, 10'h001, 10'h002, 10'h003, 10'h004};
      push_st(8'h00, 8'hFF);
      run("brz", 60, 0);
      chk_ct("brz", 15, 7);

      // PC wraps backward from 0 to 0x3FF and forward from 0x3FF to 1.
      clear_imem();
      imem[0]      = ins(OP_BRZ, 0, -1);
      imem[10'h3FF] = ins(OP_BRZ, 0, 2);
      imem[1]      = ins(OP_ST, 6, 0);
      fa_q = '{10'h000, 10'h3FF, 10'h001, 10'h002};
      push_st(8'h00, 8'hFF);
      run("wrap", 40, 0);
      chk_ct("wrap", 9, 4);

      // Endless loop: both counters saturate at all-ones.
      clear_imem();
      imem[0] = ins(OP_ADD, 3, 3);
      imem[1] = ins(OP_BRZ, 0, -1);
      @(negedge CLK) start = 1'b1;
      @(negedge CLK) start = 1'b0;
      repeat (600) @(negedge CLK);
      chk_ct("sat", 255, 255);
      chk("sat_halt", 32'(halt), 32'(0));

      // Reset while a store waits in MEM, then restart from PC 0.
      do_reset("sat_exit");
      dmem_wait = 10;
      clear_imem();
      imem[0] = ins(OP_ST, 0, 0);
      @(negedge CLK) start = 1'b1;
      @(negedge CLK) start = 1'b0;
      n = 0;
      while (bus.dmem_req !== 1'b1 && n < 20) begin
         @(negedge CLK);
         n++;
      end
      chk("memrst_reached_mem", 32'(bus.dmem_req), 32'(1));
      @(negedge CLK);
      do_reset("memrst");
      dmem_wait = 0;
      fa_q = '{10'h000, 10'h001};
      push_st(8'h00, 8'h00);
      run("restart", 40, 0);
      chk_ct("restart", 5, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
